countdown_slot_sched: RTL and testbench

- Round-robin time-slot scheduler that shares one reloadable down-counter between N requesters.
- Grants one requester at a time for a fixed slot of SLOT_LEN cycles, timed by the embedded down-counter (load, enable, count to end).
- Inserts one dead cycle between slots.
- Sits between requesting lab blocks and any shared resource that needs time-multiplexed access.

---
 rtl/countdown_slot_sched_pkg.sv | 20 ++
 rtl/countdown_slot_sched_counter.sv | 28 ++
 rtl/countdown_slot_sched.sv | 126 ++++++++++++
 tb/tb_countdown_slot_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_slot_sched_pkg.sv
// Shared types and constants for the countdown slot scheduler.
// Holds the FSM state enum, the grant-index width helper and the default slot length.
package countdown_slot_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int         DEF_N_REQ    = 4;
   localparam int         ID_W         = $clog2(DEF_N_REQ);
   localparam logic [3:0] DEF_SLOT_LEN = 4'd10;

   // Grant-index width for n requesters (never narrower than 1 bit).
   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/countdown_slot_sched_counter.sv
// Reloadable down-counter that times each grant slot.
// Ports: Clk, Clear_n (async low), Enable (decrement), Load (priority), Load_val, Q.
module slot_down_counter #(
   parameter int W = 4
) (
   input  logic         Clk,
   input  logic         Clear_n,
   input  logic         Enable,
   input  logic         Load,
   input  logic [W-1:0] Load_val,
   output logic [W-1:0] Q
);

   logic [W-1:0] r_q;

   always_ff @(posedge Clk or negedge Clear_n) begin
      if (!Clear_n) begin
         r_q <= '0;
      end else if (Load) begin
         r_q <= Load_val;
      end else if (Enable) begin
         r_q <= r_q - W'(1);
      end
   end

   assign Q = r_q;

endmodule

// File: rtl/countdown_slot_sched.sv
// Round-robin time-slot scheduler: one fixed-length grant at a time, one dead cycle between slots.
// Ports: Clk, Clear_n (async low), Req, Done (only with EARLY_RELEASE_EN), Grant, Grant_id, Busy, Remain, Slot_end.
module countdown_slot_sched
   import countdown_slot_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int CNT_W    = 4,
   parameter int SLOT_LEN = int'(DEF_SLOT_LEN)
) (
   input  logic                    Clk,
   input  logic                    Clear_n,
   input  logic [N_REQ-1:0]        Req,
`ifdef EARLY_RELEASE_EN
   input  logic [N_REQ-1:0]        Done,
`endif
   output logic [N_REQ-1:0]        Grant,
   output logic [id_w(N_REQ)-1:0]  Grant_id,
   output logic                    Busy,
   output logic [CNT_W-1:0]        Remain,
   output logic                    Slot_end
);

   localparam int IW = id_w(N_REQ);

   if (SLOT_LEN < 1 || SLOT_LEN > (2**CNT_W) - 1) begin : g_bad_len
      $error("countdown_slot_sched: SLOT_LEN out of range for CNT_W");
   end
   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("countdown_slot_sched: N_REQ must be 2..8");
   end

   state_e           r_state;
   logic [N_REQ-1:0] r_grant;
   logic [IW-1:0]    r_gid;
   logic [IW-1:0]    r_ptr;
   logic             r_busy;
   logic             r_slot_end;

   logic             w_found;
   logic [IW-1:0]    w_win;
   logic             w_early;
   logic             w_end;
   logic             w_load;
   logic             w_en;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_q;

   // Search upward from ptr+1 with wrap; first set Req bit wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!w_found && Req[IW'((int'(r_ptr) + i) % N_REQ)]) begin
            w_found = 1'b1;
            w_win   = IW'((int'(r_ptr) + i) % N_REQ);
         end
      end
   end

`ifdef EARLY_RELEASE_EN
   assign w_early = Done[r_gid];
`else
   assign w_early = 1'b0;
`endif

   // Slot ends at Remain==1 so the count never passes below 1.
   assign w_end = (w_q == CNT_W'(1)) || w_early;

   // Load SLOT_LEN on a new grant, load 0 when the slot closes.
   assign w_en       = (r_state == RUN);
   assign w_load     = (r_state == RUN) ? w_end : w_found;
   assign w_load_val = (r_state == RUN) ? '0 : CNT_W'(SLOT_LEN);

   slot_down_counter #(
      .W (CNT_W)
   ) u_cnt (
      .Clk      (Clk),
      .Clear_n  (Clear_n),
      .Enable   (w_en),
      .Load     (w_load),
      .Load_val (w_load_val),
      .Q        (w_q)
   );

   always_ff @(posedge Clk or negedge Clear_n) begin
      if (!Clear_n) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_gid      <= '0;
         r_ptr      <= IW'(N_REQ - 1);
         r_busy     <= 1'b0;
         r_slot_end <= 1'b0;
      end else begin
         r_slot_end <= 1'b0;
         unique case (r_state)
            IDLE, GAP: begin
               if (w_found) begin
                  r_state <= RUN;
                  r_grant <= N_REQ'(1) << w_win;
                  r_gid   <= w_win;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               if (w_end) begin
                  r_state    <= GAP;
                  r_grant    <= '0;
                  r_busy     <= 1'b0;
                  r_slot_end <= 1'b1;
                  r_ptr      <= r_gid;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Grant    = r_grant;
   assign Grant_id = r_gid;
   assign Busy     = r_busy;
   assign Remain   = w_q;
   assign Slot_end = r_slot_end;

endmodule

// File: tb/tb_countdown_slot_sched.sv
// Directed self-checking bench for countdown_slot_sched (N_REQ=4, SLOT_LEN=10).
// Early-release steps run only when EARLY_RELEASE_EN is defined.
module tb_countdown_slot_sched;

   logic       Clk;
   logic       Clear_n;
   logic [3:0] Req;
`ifdef EARLY_RELEASE_EN
   logic [3:0] Done;
`endif
   logic [3:0] Grant;
   logic [1:0] Grant_id;
   logic       Busy;
   logic [3:0] Remain;
   logic       Slot_end;

   int n_cmp = 0;
   int n_bad = 0;

   countdown_slot_sched #(
      .N_REQ    (4),
      .CNT_W    (4),
      .SLOT_LEN (10)
   ) dut (
      .Clk      (Clk),
      .Clear_n  (Clear_n),
      .Req      (Req),
`ifdef EARLY_RELEASE_EN
      .Done     (Done),
`endif
      .Grant    (Grant),
      .Grant_id (Grant_id),
      .Busy     (Busy),
      .Remain   (Remain),
      .Slot_end (Slot_end)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_clear(input string tag);
      chk({tag, "_grant"}, 32'(Grant), 0);
      chk({tag, "_gid"}, 32'(Grant_id), 0);
      chk({tag, "_busy"}, 32'(Busy), 0);
      chk({tag, "_remain"}, 32'(Remain), 0);
      chk({tag, "_send"}, 32'(Slot_end), 0);
   endtask

   // Entered on the first grant cycle; leaves on the GAP cycle.
   task automatic run_slot(input int id);
      logic [3:0] oh;
      oh = 4'b0001 << id;
      chk("slot_grant", 32'(Grant), 32'(oh));
      chk("slot_gid", 32'(Grant_id), id);
      chk("slot_busy", 32'(Busy), 1);
      chk("slot_remain", 32'(Remain), 10);
      chk("slot_send", 32'(Slot_end), 0);
      for (int r = 9; r >= 1; r--) begin
         step();
         chk("run_remain", 32'(Remain), r);
         chk("run_grant", 32'(Grant), 32'(oh));
      end
      step();
      chk("gap_grant", 32'(Grant), 0);
      chk("gap_busy", 32'(Busy), 0);
      chk("gap_send", 32'(Slot_end), 1);
      chk("gap_remain", 32'(Remain), 0);
      chk("gap_gid", 32'(Grant_id), id);
   endtask

   task automatic do_reset(input logic [3:0] req_during);
      Clear_n = 1'b0;
      Req     = req_during;
      #1;
      chk_clear("rst");
      step();
      chk_clear("rst_edge");
      Req     = 4'b0000;
      Clear_n = 1'b1;
   endtask

   initial begin
      Clear_n = 1'b0;
      Req     = 4'b1111;
`ifdef EARLY_RELEASE_EN
      Done    = 4'b0000;
`endif

      // 1: reset with all requests, then idle.
      #2;
      do_reset(4'b1111);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_busy", 32'(Busy), 0);
         chk("idle_grant", 32'(Grant), 0);
      end

      // 2: single requester, regrant after the gap.
      Req = 4'b0100;
      step();
      run_slot(2);
      step();
      chk("regrant_grant", 32'(Grant), 32'(4'b0100));
      chk("regrant_remain", 32'(Remain), 10);
      chk("regrant_send", 32'(Slot_end), 0);

      // 3: all requesting, order 0,1,2,3,0.
      do_reset(4'b0000);
      Req = 4'b1111;
      step();
      run_slot(0);
      step();
      run_slot(1);
      step();
      run_slot(2);
      step();
      run_slot(3);
      step();
      chk("wrap_gid", 32'(Grant_id), 0);
      chk("wrap_grant", 32'(Grant), 32'(4'b0001));

      // 4: async reset mid-slot of id 1.
      run_slot(0);
      step();
      chk("pre_rst_gid", 32'(Grant_id), 1);
      for (int i = 0; i < 5; i++) step();
      chk("pre_rst_remain", 32'(Remain), 5);
      Clear_n = 1'b0;
      #1;
      chk("midrst_grant", 32'(Grant), 0);
      chk("midrst_remain", 32'(Remain), 0);
      chk("midrst_busy", 32'(Busy), 0);
      #1;
      Clear_n = 1'b1;
      step();
      chk("post_rst_grant", 32'(Grant), 32'(4'b0001));
      chk("post_rst_gid", 32'(Grant_id), 0);

      // 5: from last grantee 1, Req=1010 gives 3 then 1.
      do_reset(4'b0000);
      Req = 4'b0010;
      step();
      Req = 4'b1010;
      run_slot(1);
      step();
      run_slot(3);
      step();
      chk("rr_gid", 32'(Grant_id), 1);
      chk("rr_remain", 32'(Remain), 10);
      for (int i = 0; i < 3; i++) step();
      chk("drop_remain", 32'(Remain), 7);
      Req = 4'b0000;
      for (int r = 6; r >= 1; r--) begin
         step();
         chk("drop_run_remain", 32'(Remain), r);
         chk("drop_run_grant", 32'(Grant), 32'(4'b0010));
      end
      step();
      chk("drop_end_send", 32'(Slot_end), 1);
      chk("drop_end_grant", 32'(Grant), 0);
      step();
      chk("to_idle_grant", 32'(Grant), 0);
      chk("to_idle_send", 32'(Slot_end), 0);
      chk("to_idle_gid", 32'(Grant_id), 1);
      chk("to_idle_busy", 32'(Busy), 0);

`ifdef EARLY_RELEASE_EN
      // 6: early release by the grantee only.
      do_reset(4'b0000);
      Req = 4'b0010;
      step();
      Req = 4'b0000;
      for (int i = 0; i < 3; i++) step();
      chk("er_remain", 32'(Remain), 7);
      Done = 4'b1000;
      step();
      chk("er_ign_grant", 32'(Grant), 32'(4'b0010));
      chk("er_ign_remain", 32'(Remain), 6);
      Done = 4'b0010;
      step();
      chk("er_grant", 32'(Grant), 0);
      chk("er_send", 32'(Slot_end), 1);
      chk("er_remain0", 32'(Remain), 0);
      Done = 4'b0000;
      step();
      chk("er_idle_send", 32'(Slot_end), 0);
      chk("er_idle_grant", 32'(Grant), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
